// File: rtl/jk_lockstep_monitor_pkg.sv
// Shared definitions for the JK lockstep monitor: FSM state encoding and the
// reference JK next-state function, also reused by the flip-flop stage bench.
package jk_lockstep_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_RUN   = 2'd2,
        ST_FAULT = 2'd3
    } mon_state_t;

    function automatic logic jk_next(input logic q, input logic j, input logic k);
        case ({j, k})
            2'b00:   return q;
            2'b01:   return 1'b0;
            2'b10:   return 1'b1;
            default: return ~q;
        endcase
    endfunction

endpackage

// File: rtl/jk_ref_model.sv
// Golden JK register: loaded from the observed stage output while arming,
// then stepped from the shared J/K nets while the monitor is running.
module jk_ref_model
    import jk_lockstep_monitor_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic load_val,
    input  logic step,
    input  logic J,
    input  logic K,
    output logic q
);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, matching the stage being shadowed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= 1'b0;
        end else if (load) begin
            q <= load_val;
        end else if (step) begin
            q <= jk_next(q, J, K);
        end
    end

endmodule

// File: rtl/jk_lockstep_monitor.sv
// Lockstep checker for the three-way jk_flip_flop stage: runs a golden model,
// flags per-implementation divergence, counts errors/toggles and votes Q.
module jk_lockstep_monitor
    import jk_lockstep_monitor_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int ARM_CYCLES  = 2,
    parameter int FAULT_LIMIT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             J,
    input  logic             K,
    input  logic             Q_sr,
    input  logic             Q_d,
    input  logic             Q_t,
    output logic             q_exp,
    output logic             q_vote,
    output logic [2:0]       mismatch,
    output logic [2:0]       sticky,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] toggle_cnt,
    output logic [1:0]       state,
    output logic             fault
);

    localparam int ARM_W = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;
    localparam logic [ARM_W-1:0] ARM_LAST  = ARM_W'(ARM_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] ERR_LIMIT = CNT_W'(FAULT_LIMIT);

    mon_state_t       st;
    logic [ARM_W-1:0] arm_cnt;
    logic             q_d_prev;

    logic             active;
    logic             load;
    logic             step;
    logic [2:0]       diff;
    logic             any_diff;
    logic [CNT_W-1:0] err_inc;

    // clr and en=0 both pre-empt the golden model, so it only moves on live edges.
    assign active   = en && !clr;
    assign load     = (st == ST_ARM) && active;
    assign step     = (st == ST_RUN) && active;

    assign diff     = {Q_t, Q_d, Q_sr} ^ {3{q_exp}};
    assign any_diff = |diff;
    assign err_inc  = (err_cnt == CNT_MAX) ? err_cnt : err_cnt + CNT_W'(1);

    assign q_vote   = (Q_sr & Q_d) | (Q_sr & Q_t) | (Q_d & Q_t);
    assign state    = st;

    jk_ref_model u_ref (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (Q_d),
        .step     (step),
        .J        (J),
        .K        (K),
        .q        (q_exp)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st         <= ST_IDLE;
            arm_cnt    <= '0;
            q_d_prev   <= 1'b0;
            mismatch   <= '0;
            sticky     <= '0;
            err_cnt    <= '0;
            toggle_cnt <= '0;
            fault      <= 1'b0;
        end else begin
            q_d_prev <= Q_d;
            if (clr) begin
                st         <= ST_IDLE;
                mismatch   <= '0;
                sticky     <= '0;
                err_cnt    <= '0;
                toggle_cnt <= '0;
                fault      <= 1'b0;
            end else if (st == ST_FAULT) begin
                mismatch <= '0;
                fault    <= 1'b1;
            end else if (!en) begin
                st       <= ST_IDLE;
                mismatch <= '0;
            end else begin
                case (st)
                    ST_IDLE: begin
                        st      <= ST_ARM;
                        arm_cnt <= '0;
                    end
                    ST_ARM: begin
                        arm_cnt <= arm_cnt + ARM_W'(1);
                        if (arm_cnt == ARM_LAST) st <= ST_RUN;
                    end
                    ST_RUN: begin
                        mismatch <= diff;
                        sticky   <= sticky | diff;
                        if (Q_d != q_d_prev) toggle_cnt <= toggle_cnt + CNT_W'(1);
                        if (any_diff) begin
                            err_cnt <= err_inc;
                            // Entering FAULT suppresses the flag pulse; sticky still records it.
                            if (err_inc >= ERR_LIMIT) begin
                                st       <= ST_FAULT;
                                fault    <= 1'b1;
                                mismatch <= '0;
                            end
                        end
                    end
                    default: begin
                        mismatch <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jk_lockstep_monitor.sv
// Table-driven bench for jk_lockstep_monitor with a behavioural JK stage whose
// outputs can be inverted per cycle to inject divergence.
module tb_jk_lockstep_monitor;

    typedef struct {
        logic       en;
        logic       clr;
        logic       j;
        logic       k;
        logic [2:0] inv;
        logic [1:0] st;
        logic [2:0] mm;
        logic [2:0] stk;
        int         err;
        int         tog;
        logic       qx;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       en, clr, J, K;
    logic       Q_sr, Q_d, Q_t;

    logic       q_exp, q_vote, fault;
    logic [2:0] mismatch, sticky;
    logic [7:0] err_cnt, toggle_cnt;
    logic [1:0] state;

    logic       q_exp4, q_vote4, fault4;
    logic [2:0] mismatch4, sticky4;
    logic [3:0] err_cnt4, toggle_cnt4;
    logic [1:0] state4;

    vec_t       vecs[$];
    int         checks = 0;
    int         errors = 0;
    logic       q_stage;
    logic [7:0] vote_tbl;

    always #5 clk = ~clk;

    jk_lockstep_monitor #(.CNT_W(8), .ARM_CYCLES(2), .FAULT_LIMIT(3)) dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .J(J), .K(K),
        .Q_sr(Q_sr), .Q_d(Q_d), .Q_t(Q_t),
        .q_exp(q_exp), .q_vote(q_vote), .mismatch(mismatch), .sticky(sticky),
        .err_cnt(err_cnt), .toggle_cnt(toggle_cnt), .state(state), .fault(fault)
    );

    jk_lockstep_monitor #(.CNT_W(4), .ARM_CYCLES(2), .FAULT_LIMIT(3)) dut4 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .J(J), .K(K),
        .Q_sr(Q_sr), .Q_d(Q_d), .Q_t(Q_t),
        .q_exp(q_exp4), .q_vote(q_vote4), .mismatch(mismatch4), .sticky(sticky4),
        .err_cnt(err_cnt4), .toggle_cnt(toggle_cnt4), .state(state4), .fault(fault4)
    );

    function automatic logic stage_next(input logic q, input logic j, input logic k);
        if (j && k) return ~q;
        if (j)      return 1'b1;
        if (k)      return 1'b0;
        return q;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic e, input logic c, input logic j, input logic k,
                       input logic [2:0] inv, input logic [1:0] st, input logic [2:0] mm,
                       input logic [2:0] stk, input int err, input int tog, input logic qx);
        vec_t v;
        v.en = e; v.clr = c; v.j = j; v.k = k; v.inv = inv;
        v.st = st; v.mm = mm; v.stk = stk; v.err = err; v.tog = tog; v.qx = qx;
        vecs.push_back(v);
    endtask

    // One clock: drive inputs, take the edge, then update the stage outputs.
    task automatic cyc(input logic e, input logic c, input logic j, input logic k,
                       input logic [2:0] inv);
        en = e; clr = c; J = j; K = k;
        @(posedge clk);
        #1;
        q_stage = stage_next(q_stage, j, k);
        Q_sr = q_stage ^ inv[0];
        Q_d  = q_stage ^ inv[1];
        Q_t  = q_stage ^ inv[2];
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // arm + clean run (00,01,10,11 x4)
        add(1,0,0,0,3'b000, 1,3'b000,3'b000,0,0,0);
        add(1,0,0,0,3'b000, 1,3'b000,3'b000,0,0,0);
        add(1,0,0,0,3'b000, 2,3'b000,3'b000,0,0,0);
        add(1,0,0,0,3'b000, 2,3'b000,3'b000,0,0,0);
        add(1,0,0,1,3'b000, 2,3'b000,3'b000,0,0,0);
        add(1,0,1,0,3'b000, 2,3'b000,3'b000,0,0,1);
        add(1,0,1,1,3'b000, 2,3'b000,3'b000,0,1,0);
        add(1,0,0,0,3'b000, 2,3'b000,3'b000,0,2,0);
        add(1,0,0,1,3'b000, 2,3'b000,3'b000,0,2,0);
        add(1,0,1,0,3'b000, 2,3'b000,3'b000,0,2,1);
        add(1,0,1,1,3'b000, 2,3'b000,3'b000,0,3,0);
        add(1,0,0,0,3'b000, 2,3'b000,3'b000,0,4,0);
        add(1,0,0,1,3'b000, 2,3'b000,3'b000,0,4,0);
        add(1,0,1,0,3'b000, 2,3'b000,3'b000,0,4,1);
        add(1,0,1,1,3'b000, 2,3'b000,3'b000,0,5,0);
        add(1,0,0,0,3'b000, 2,3'b000,3'b000,0,6,0);
        add(1,0,0,1,3'b000, 2,3'b000,3'b000,0,6,0);
        add(1,0,1,0,3'b000, 2,3'b000,3'b000,0,6,1);
        add(1,0,1,1,3'b000, 2,3'b000,3'b000,0,7,0);
        // single Q_t fault
        add(1,0,0,0,3'b100, 2,3'b000,3'b000,0,8,0);
        add(1,0,0,0,3'b000, 2,3'b100,3'b100,1,8,0);
        add(1,0,0,0,3'b000, 2,3'b000,3'b100,1,8,0);
        // clr with en, re-arm, Q_sr stuck-at-1 up to the fault limit
        add(1,1,0,0,3'b000, 0,3'b000,3'b000,0,0,0);
        add(1,0,0,0,3'b000, 1,3'b000,3'b000,0,0,0);
        add(1,0,0,0,3'b000, 1,3'b000,3'b000,0,0,0);
        add(1,0,0,0,3'b000, 2,3'b000,3'b000,0,0,0);
        add(1,0,0,0,3'b001, 2,3'b000,3'b000,0,0,0);
        add(1,0,0,0,3'b001, 2,3'b001,3'b001,1,0,0);
        add(1,0,0,0,3'b001, 2,3'b001,3'b001,2,0,0);
        add(1,0,0,0,3'b001, 3,3'b000,3'b001,3,0,0);
        add(0,0,0,0,3'b001, 3,3'b000,3'b001,3,0,0);
        add(1,0,0,0,3'b001, 3,3'b000,3'b001,3,0,0);
        add(0,1,0,0,3'b000, 0,3'b000,3'b000,0,0,0);
        // re-arm, Q_d divergence, clr with en while in RUN
        add(1,0,0,0,3'b000, 1,3'b000,3'b000,0,0,0);
        add(1,0,0,0,3'b000, 1,3'b000,3'b000,0,0,0);
        add(1,0,0,0,3'b000, 2,3'b000,3'b000,0,0,0);
        add(1,0,1,0,3'b000, 2,3'b000,3'b000,0,0,1);
        add(1,0,0,0,3'b000, 2,3'b000,3'b000,0,1,1);
        add(1,0,0,0,3'b010, 2,3'b000,3'b000,0,1,1);
        add(1,0,0,0,3'b000, 2,3'b010,3'b010,1,2,1);
        add(1,1,0,0,3'b000, 0,3'b000,3'b000,0,0,1);
        // re-arm from Q_d=1, then en=0 drops a pending mismatch
        add(1,0,0,0,3'b000, 1,3'b000,3'b000,0,0,1);
        add(1,0,0,0,3'b000, 1,3'b000,3'b000,0,0,1);
        add(1,0,0,0,3'b000, 2,3'b000,3'b000,0,0,1);
        add(1,0,0,1,3'b000, 2,3'b000,3'b000,0,0,0);
        add(1,0,0,0,3'b100, 2,3'b000,3'b000,0,1,0);
        add(0,0,0,0,3'b000, 0,3'b000,3'b000,0,1,0);

        // reset with random inputs
        rst = 1'b0;
        repeat (2) begin
            en = 1'($urandom); clr = 1'($urandom); J = 1'($urandom); K = 1'($urandom);
            Q_sr = 1'($urandom); Q_d = 1'($urandom); Q_t = 1'($urandom);
            @(posedge clk);
            #1;
        end
        check("rst state",    32'(state), 32'd0);
        check("rst q_exp",    32'(q_exp), 32'd0);
        check("rst mismatch", 32'(mismatch), 32'd0);
        check("rst sticky",   32'(sticky), 32'd0);
        check("rst err_cnt",  32'(err_cnt), 32'd0);
        check("rst tog_cnt",  32'(toggle_cnt), 32'd0);
        check("rst fault",    32'(fault), 32'd0);

        en = 1'b0; clr = 1'b0; J = 1'b0; K = 1'b0;
        q_stage = 1'b0; Q_sr = 1'b0; Q_d = 1'b0; Q_t = 1'b0;
        #2 rst = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            cyc(vecs[i].en, vecs[i].clr, vecs[i].j, vecs[i].k, vecs[i].inv);
            check($sformatf("row%0d state", i),    32'(state),      32'(vecs[i].st));
            check($sformatf("row%0d fault", i),    32'(fault),      32'(vecs[i].st == 2'd3));
            check($sformatf("row%0d mismatch", i), 32'(mismatch),   32'(vecs[i].mm));
            check($sformatf("row%0d sticky", i),   32'(sticky),     32'(vecs[i].stk));
            check($sformatf("row%0d err_cnt", i),  32'(err_cnt),    32'(vecs[i].err));
            check($sformatf("row%0d tog_cnt", i),  32'(toggle_cnt), 32'(vecs[i].tog));
            check($sformatf("row%0d q_exp", i),    32'(q_exp),      32'(vecs[i].qx));
            check($sformatf("row%0d state4", i),   32'(state4),     32'(vecs[i].st));
        end

        // majority vote over all input combinations, index = {Q_t,Q_d,Q_sr}
        vote_tbl = 8'b1110_1000;
        for (int i = 0; i < 8; i++) begin
            {Q_t, Q_d, Q_sr} = 3'(i);
            #1;
            check($sformatf("vote %0d", i), 32'(q_vote), 32'(vote_tbl[i]));
        end
        Q_sr = q_stage; Q_d = q_stage; Q_t = q_stage;
        @(posedge clk);
        #1;

        // toggle counter wrap: 17 Q_d transitions in RUN
        cyc(0, 1, 0, 0, 3'b000);
        repeat (3) cyc(1, 0, 0, 0, 3'b000);
        check("wrap pre state", 32'(state), 32'd2);
        repeat (18) cyc(1, 0, 1, 1, 3'b000);
        check("wrap tog8",  32'(toggle_cnt),  32'd17);
        check("wrap tog4",  32'(toggle_cnt4), 32'd1);
        check("wrap err8",  32'(err_cnt),     32'd0);
        check("wrap state", 32'(state4),      32'd2);

        // asynchronous reset mid-RUN
        #3 rst = 1'b0;
        #1;
        check("async state",  32'(state),       32'd0);
        check("async tog8",   32'(toggle_cnt),  32'd0);
        check("async tog4",   32'(toggle_cnt4), 32'd0);
        check("async q_exp",  32'(q_exp),       32'd0);
        check("async mm",     32'(mismatch),    32'd0);

        // restart: ARM resyncs the golden model to a stage now holding 1
        q_stage = 1'b1; Q_sr = 1'b1; Q_d = 1'b1; Q_t = 1'b1;
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) cyc(1, 0, 0, 0, 3'b000);
        check("resync state", 32'(state), 32'd2);
        check("resync q_exp", 32'(q_exp), 32'd1);
        cyc(1, 0, 0, 0, 3'b000);
        check("resync mm",    32'(mismatch),   32'd0);
        check("resync tog",   32'(toggle_cnt), 32'd0);
        check("resync err",   32'(err_cnt),    32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
